lpc_target_engine: RTL and testbench
====================================

# lpc_target_engine

Parametrised LPC bus target for the TPM interface: decodes host-initiated I/O and memory cycles (including TPM-style `0101` START) on LAD/LFRAME#, matches addresses against configurable windows and hands each hit to a backend over a valid/ready request port. Unlike the fixed single-mode translator, it inserts long-wait SYNCs while the backend is busy, reports SYNC errors on timeout and aborts cleanly on LFRAME#. It sits between the LPC pins (tristate handled at top level via `enable`) and the TPM register file.

## Interface
- `ADDR_W`, 32, width of `addr` (I/O addresses zero-extended)
- `MEM_EN`, 1, accept memory cycles (0 = I/O only)
- `IO_BASE` / `IO_MASK`, 16'h002E / 16'hFFFE, I/O hit when `(a & IO_MASK) == IO_BASE`
- `MEM_BASE` / `MEM_MASK`, 32'hFED4_0000 / 32'hFFFF_0000, memory window
- `WAIT_LIMIT`, 255, max long-wait SYNC cycles before error SYNC (≥1)

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1 LPC clock, rising edge
- `rstN` in 1 async active-low reset
- `frame` in 1 LFRAME#, active low
- `inAd` in 4 sampled LAD
- `outAd` out 4 LAD drive value
- `enable` out 1 LAD output enable
- `addr` out ADDR_W latched cycle address
- `isMem` out 1 latched cycle is memory
- `outData` out 8 latched write data
- `inData` in 8 read data, valid with `reqReady`
- `reqValid` out 1 backend request
- `reqWrite` out 1 request direction
- `reqReady` in 1 backend accept
- `didWrite` / `didRead` out 1 one-cycle pulse on completed cycle
- `syncError` out 1 one-cycle pulse on timeout

## Operation
- Reset: `outAd`=4'hF, `enable`=0, `reqValid`=0, `reqWrite`=0, `addr`/`outData`=0, `isMem`=0, pulses 0, state IDLE.
- States: IDLE, CYC, ADDR, WDAT0, WDAT1, HTAR0, HTAR1, SYNC, RDAT0, RDAT1, TTAR0, TTAR1.
- START: while `frame`=0 latch `inAd`; the last nibble seen low is START. Valid: `0000`, or `0101` when `MEM_EN`. First cycle `frame`=1 after valid START → sample CYCTYPE.
- CYCTYPE `inAd[3:2]`: 00 I/O (4 addr nibbles), 01 memory (8 nibbles, needs MEM_EN); other → IDLE. `inAd[1]`: 1 write.
- Address MSN first, shifted into `addr`. After last nibble, window compare; miss → IDLE, never drives LAD.
- Write: WDAT0 low nibble, WDAT1 high nibble into `outData`; `reqValid`=1, `reqWrite`=1 from HTAR0 until `reqReady`.
- Read hit: `reqValid`=1, `reqWrite`=0 from cycle after last address nibble until `reqReady`; `inData` captured on handshake.
- HTAR0/HTAR1: `enable`=0.
- SYNC: `enable`=1; `outAd`=`0000` if handshake done, else `0110` and wait counter increments. Counter reaching `WAIT_LIMIT` → `outAd`=`1010`, drop `reqValid`, pulse `syncError`, go TTAR0 (no data).
- Read after `0000`: RDAT0 low nibble, RDAT1 high nibble, then TTAR0 drives `1111`, TTAR1 `enable`=0 → IDLE. Write after `0000` → TTAR0/TTAR1.
- `didWrite`/`didRead` pulse in TTAR0 of a successful cycle.
- Abort: `frame`=0 in any non-IDLE state → `enable`=0, `reqValid`=0 next edge, no pulse, that nibble treated as START.
- Async reset mid-cycle: all outputs to reset values immediately.

## Timing
- All outputs registered; values change after the clock edge entering a state.
- I/O write no-wait: START t0, CYC t1, ADDR t2–t5, WDAT t6–t7, HTAR t8–t9, SYNC t10, TTAR t11–t12; `didWrite` high at t11.
- Handshake completes on the edge where `reqValid`&&`reqReady`; ready in the same cycle as HTAR1 yields `0000` at the first SYNC.
- Each extra busy cycle adds exactly one `0110` SYNC.

## Structure
- Package `lpc_pkg`: state enum, SYNC codes (`SYNC_READY`=0000, `SYNC_LWAIT`=0110, `SYNC_ERR`=1010), START codes, CYCTYPE field constants.
- One sub-module natural: `lpc_addr_match` (combinational window compare for I/O and memory).

## Test plan
- I/O write 0x002E data 0x5A, `reqReady` tied 1 → `outData`=0x5A, `addr`=0x2E, SYNC `0000` at t10, `didWrite` pulse at t11.
- Memory read 0xFED4_0014 via START `0101`, `reqReady` after 3 SYNCs with `inData`=0xC3 → LAD `0110`×3, `0000`, `0011`, `1100`, `1111`; `didRead` pulse.
- I/O write to 0x0080 (miss) → `enable` never 1, `reqValid` never 1.
- `frame` low during ADDR nibble 2 → `reqValid` stays 0, new START decoded, following cycle completes normally.
- Read with `reqReady`=0 and `WAIT_LIMIT`=4 → four `0110`, then `1010`, `syncError` pulse, no `didRead`.
- `rstN` low during SYNC → `enable`=0, `outAd`=F, `reqValid`=0 without a clock edge.

Source files
------------

// File: rtl/lpc_pkg.sv
// Shared LPC target types: FSM states, SYNC/START codes and CYCTYPE fields.
package lpc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CYC,
    ST_ADDR,
    ST_WDAT0,
    ST_WDAT1,
    ST_HTAR0,
    ST_HTAR1,
    ST_SYNC,
    ST_RDAT0,
    ST_RDAT1,
    ST_TTAR0,
    ST_TTAR1
  } lpc_state_e;

  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_LWAIT = 4'b0110;
  localparam logic [3:0] SYNC_ERR   = 4'b1010;

  localparam logic [3:0] START_IO   = 4'b0000;
  localparam logic [3:0] START_TPM  = 4'b0101;

  localparam logic [1:0] CYC_IO     = 2'b00;
  localparam logic [1:0] CYC_MEM    = 2'b01;

  localparam logic [3:0] LAD_IDLE   = 4'hF;

  // A START nibble opens a cycle only if it is one this target decodes.
  function automatic logic start_valid(input logic [3:0] nib, input logic mem_en);
    return (nib == START_IO) || (mem_en && (nib == START_TPM));
  endfunction

endpackage

// File: rtl/lpc_addr_match.sv
// Combinational address window compare for I/O and memory cycles.
module lpc_addr_match
  import lpc_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter logic        MEM_EN   = 1'b1,
  parameter logic [15:0] IO_BASE  = 16'h002E,
  parameter logic [15:0] IO_MASK  = 16'hFFFE,
  parameter logic [31:0] MEM_BASE = 32'hFED4_0000,
  parameter logic [31:0] MEM_MASK = 32'hFFFF_0000
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              is_mem_i,
  output logic              hit_c
);

  logic io_hit_c;
  logic mem_hit_c;

  // I/O addresses arrive zero-extended, so only the low 16 bits matter.
  always_comb begin
    io_hit_c  = ((addr_i[15:0] & IO_MASK) == IO_BASE);
    mem_hit_c = MEM_EN && ((addr_i & ADDR_W'(MEM_MASK)) == ADDR_W'(MEM_BASE));
    hit_c     = is_mem_i ? mem_hit_c : io_hit_c;
  end

endmodule

// File: rtl/lpc_target_engine.sv
// LPC bus target: decodes I/O / memory cycles, forwards hits to a backend,
// inserts long-wait SYNCs while it is busy and errors out on timeout.
module lpc_target_engine
  import lpc_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter logic        MEM_EN     = 1'b1,
  parameter logic [15:0] IO_BASE    = 16'h002E,
  parameter logic [15:0] IO_MASK    = 16'hFFFE,
  parameter logic [31:0] MEM_BASE   = 32'hFED4_0000,
  parameter logic [31:0] MEM_MASK   = 32'hFFFF_0000,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              frame,
  input  logic [3:0]        inAd,
  output logic [3:0]        outAd,
  output logic              enable,
  output logic [ADDR_W-1:0] addr,
  output logic              isMem,
  output logic [7:0]        outData,
  input  logic [7:0]        inData,
  output logic              reqValid,
  output logic              reqWrite,
  input  logic              reqReady,
  output logic              didWrite,
  output logic              didRead,
  output logic              syncError
);

  localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);

  lpc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              is_mem_q, is_mem_d;
  logic              wr_q, wr_d;
  logic [2:0]        nib_q, nib_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic              req_valid_q, req_valid_d;
  logic [3:0]        out_ad_q, out_ad_d;
  logic              enable_q, enable_d;
  logic              did_write_q, did_write_d;
  logic              did_read_q, did_read_d;
  logic              sync_err_q, sync_err_d;

  logic              hs_c;
  logic [ADDR_W-1:0] addr_shift_c;
  logic              hit_c;

  lpc_addr_match #(
    .ADDR_W   (ADDR_W),
    .MEM_EN   (MEM_EN),
    .IO_BASE  (IO_BASE),
    .IO_MASK  (IO_MASK),
    .MEM_BASE (MEM_BASE),
    .MEM_MASK (MEM_MASK)
  ) u_match (
    .addr_i   (addr_shift_c),
    .is_mem_i (is_mem_q),
    .hit_c    (hit_c)
  );

  // Next-state and registered-output decode; LAD idles released unless set.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    is_mem_d    = is_mem_q;
    wr_d        = wr_q;
    nib_d       = nib_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    done_d      = done_q;
    wcnt_d      = wcnt_q;
    req_valid_d = req_valid_q;
    out_ad_d    = LAD_IDLE;
    enable_d    = 1'b0;
    did_write_d = 1'b0;
    did_read_d  = 1'b0;
    sync_err_d  = 1'b0;
    hs_c         = req_valid_q && reqReady;
    addr_shift_c = {addr_q[ADDR_W-5:0], inAd};

    if (hs_c) begin
      req_valid_d = 1'b0;
      done_d      = 1'b1;
      if (!wr_q) rdata_d = inData;
    end

    if (!frame) begin
      // LFRAME# low anywhere restarts framing; this nibble is the START.
      req_valid_d = 1'b0;
      state_d     = start_valid(inAd, MEM_EN) ? ST_CYC : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_CYC: begin
          addr_d  = '0;
          done_d  = 1'b0;
          wcnt_d  = '0;
          wr_d    = inAd[1];
          state_d = ST_IDLE;
          if (inAd[3:2] == CYC_IO) begin
            is_mem_d = 1'b0;
            nib_d    = 3'd3;
            state_d  = ST_ADDR;
          end else if ((inAd[3:2] == CYC_MEM) && MEM_EN) begin
            is_mem_d = 1'b1;
            nib_d    = 3'd7;
            state_d  = ST_ADDR;
          end
        end
        ST_ADDR: begin
          addr_d = addr_shift_c;
          if (nib_q == 3'd0) begin
            if (hit_c) begin
              state_d     = wr_q ? ST_WDAT0 : ST_HTAR0;
              req_valid_d = !wr_q;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            nib_d = nib_q - 3'd1;
          end
        end
        ST_WDAT0: begin
          wdata_d[3:0] = inAd;
          state_d      = ST_WDAT1;
        end
        ST_WDAT1: begin
          wdata_d[7:4] = inAd;
          req_valid_d  = 1'b1;
          state_d      = ST_HTAR0;
        end
        ST_HTAR0: state_d = ST_HTAR1;
        ST_HTAR1: begin
          state_d  = ST_SYNC;
          enable_d = 1'b1;
          if (done_q || hs_c) begin
            out_ad_d = SYNC_READY;
          end else begin
            out_ad_d = SYNC_LWAIT;
            wcnt_d   = CNT_W'(1);
          end
        end
        ST_SYNC: begin
          enable_d = 1'b1;
          if (out_ad_q == SYNC_READY) begin
            if (wr_q) begin
              state_d     = ST_TTAR0;
              did_write_d = 1'b1;
            end else begin
              state_d  = ST_RDAT0;
              out_ad_d = rdata_q[3:0];
            end
          end else if (out_ad_q == SYNC_ERR) begin
            state_d = ST_TTAR0;
          end else if (hs_c) begin
            out_ad_d = SYNC_READY;
          end else if (wcnt_q >= CNT_W'(WAIT_LIMIT)) begin
            out_ad_d    = SYNC_ERR;
            req_valid_d = 1'b0;
            sync_err_d  = 1'b1;
          end else begin
            out_ad_d = SYNC_LWAIT;
            wcnt_d   = wcnt_q + CNT_W'(1);
          end
        end
        ST_RDAT0: begin
          state_d  = ST_RDAT1;
          enable_d = 1'b1;
          out_ad_d = rdata_q[7:4];
        end
        ST_RDAT1: begin
          state_d    = ST_TTAR0;
          enable_d   = 1'b1;
          did_read_d = 1'b1;
        end
        ST_TTAR0: state_d = ST_TTAR1;
        ST_TTAR1: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      is_mem_q    <= 1'b0;
      wr_q        <= 1'b0;
      nib_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      wcnt_q      <= '0;
      req_valid_q <= 1'b0;
      out_ad_q    <= LAD_IDLE;
      enable_q    <= 1'b0;
      did_write_q <= 1'b0;
      did_read_q  <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      is_mem_q    <= is_mem_d;
      wr_q        <= wr_d;
      nib_q       <= nib_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      wcnt_q      <= wcnt_d;
      req_valid_q <= req_valid_d;
      out_ad_q    <= out_ad_d;
      enable_q    <= enable_d;
      did_write_q <= did_write_d;
      did_read_q  <= did_read_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign outAd     = out_ad_q;
  assign enable    = enable_q;
  assign addr      = addr_q;
  assign isMem     = is_mem_q;
  assign outData   = wdata_q;
  assign reqValid  = req_valid_q;
  assign reqWrite  = req_valid_q && wr_q;
  assign didWrite  = did_write_q;
  assign didRead   = did_read_q;
  assign syncError = sync_err_q;

endmodule

// File: tb/tb_lpc_target_engine.sv
// Directed bench for lpc_target_engine with a LAD-drive scoreboard.
module tb_lpc_target_engine;

  logic        clk;
  logic        rstN;
  logic        frame;
  logic [3:0]  inAd;
  logic [3:0]  outAd;
  logic        enable;
  logic [31:0] addr;
  logic        isMem;
  logic [7:0]  outData;
  logic [7:0]  inData;
  logic        reqValid;
  logic        reqWrite;
  logic        reqReady;
  logic        didWrite;
  logic        didRead;
  logic        syncError;

  int checks = 0;
  int errors = 0;
  int n_dw, n_dr, n_se, n_rv;
  logic [3:0] exp_q[$];

  lpc_target_engine #(.WAIT_LIMIT(4)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .frame     (frame),
    .inAd      (inAd),
    .outAd     (outAd),
    .enable    (enable),
    .addr      (addr),
    .isMem     (isMem),
    .outData   (outData),
    .inData    (inData),
    .reqValid  (reqValid),
    .reqWrite  (reqWrite),
    .reqReady  (reqReady),
    .didWrite  (didWrite),
    .didRead   (didRead),
    .syncError (syncError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample just after the edge and score any LAD drive.
  task automatic step();
    logic [3:0] e;
    @(posedge clk);
    #1;
    if (didWrite === 1'b1) n_dw++;
    if (didRead === 1'b1) n_dr++;
    if (syncError === 1'b1) n_se++;
    if (reqValid === 1'b1) n_rv++;
    if (enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("lad_unexpected_drive", 32'(enable), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("lad", 32'(outAd), 32'(e));
      end
    end
  endtask

  task automatic do_start(input logic [3:0] s);
    frame = 1'b0;
    inAd  = s;
    step();
    frame = 1'b1;
    inAd  = 4'hF;
  endtask

  task automatic do_nib(input logic [3:0] n);
    inAd = n;
    step();
  endtask

  task automatic send_addr(input logic [31:0] a, input int n);
    logic [31:0] v;
    v = a;
    for (int i = n - 1; i >= 0; i--) do_nib(v[i*4 +: 4]);
  endtask

  task automatic clr_counts();
    n_dw = 0;
    n_dr = 0;
    n_se = 0;
    n_rv = 0;
  endtask

  initial begin
    rstN     = 1'b0;
    frame    = 1'b1;
    inAd     = 4'hF;
    inData   = 8'h00;
    reqReady = 1'b0;
    clr_counts();
    #12;
    chk("rst_outAd", 32'(outAd), 32'hF);
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_reqValid", 32'(reqValid), 32'd0);
    chk("rst_reqWrite", 32'(reqWrite), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_outData", 32'(outData), 32'd0);
    chk("rst_isMem", 32'(isMem), 32'd0);
    chk("rst_pulses", {29'd0, didWrite, didRead, syncError}, 32'd0);
    rstN = 1'b1;
    step();
    step();

    // I/O write 0x2E <- 0x5A, backend always ready.
    clr_counts();
    reqReady = 1'b1;
    exp_q.push_back(4'h0);
    exp_q.push_back(4'hF);
    do_start(4'b0000);
    do_nib(4'b0010);
    send_addr(32'h2E, 4);
    do_nib(4'hA);
    do_nib(4'h5);
    chk("wr_reqValid_htar0", 32'(reqValid), 32'd1);
    chk("wr_reqWrite_htar0", 32'(reqWrite), 32'd1);
    chk("wr_outData", 32'(outData), 32'h5A);
    chk("wr_addr", addr, 32'h2E);
    chk("wr_isMem", 32'(isMem), 32'd0);
    do_nib(4'hF);
    chk("wr_htar1_enable", 32'(enable), 32'd0);
    do_nib(4'hF);
    chk("wr_sync_t10", {27'd0, enable, outAd}, 32'h10);
    step();
    chk("wr_didWrite_t11", 32'(didWrite), 32'd1);
    step();
    chk("wr_didWrite_t12", 32'(didWrite), 32'd0);
    chk("wr_ttar1_enable", 32'(enable), 32'd0);
    step();
    chk("wr_dw_count", 32'(n_dw), 32'd1);
    chk("wr_q_empty", 32'(exp_q.size()), 32'd0);

    // Memory read 0xFED40014 via TPM START with three long waits.
    clr_counts();
    reqReady = 1'b0;
    inData   = 8'hC3;
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b1100);
    exp_q.push_back(4'b1111);
    do_start(4'b0101);
    do_nib(4'b0100);
    send_addr(32'hFED4_0014, 8);
    chk("rd_reqValid_htar0", 32'(reqValid), 32'd1);
    chk("rd_reqWrite_htar0", 32'(reqWrite), 32'd0);
    chk("rd_isMem", 32'(isMem), 32'd1);
    chk("rd_addr", addr, 32'hFED4_0014);
    do_nib(4'hF);
    do_nib(4'hF);
    step();
    step();
    reqReady = 1'b1;
    step();
    reqReady = 1'b0;
    inData   = 8'h00;
    chk("rd_reqValid_dropped", 32'(reqValid), 32'd0);
    step();
    step();
    step();
    chk("rd_didRead", 32'(didRead), 32'd1);
    step();
    step();
    chk("rd_dr_count", 32'(n_dr), 32'd1);
    chk("rd_se_count", 32'(n_se), 32'd0);
    chk("rd_q_empty", 32'(exp_q.size()), 32'd0);

    // I/O write to 0x80 misses the window: no drive, no request.
    clr_counts();
    reqReady = 1'b1;
    do_start(4'b0000);
    do_nib(4'b0010);
    send_addr(32'h80, 4);
    do_nib(4'h1);
    do_nib(4'h2);
    for (int i = 0; i < 6; i++) step();
    chk("miss_rv_count", 32'(n_rv), 32'd0);
    chk("miss_dw_count", 32'(n_dw), 32'd0);

    // LFRAME# drops mid-address; the restarted cycle must complete.
    clr_counts();
    exp_q.push_back(4'h0);
    exp_q.push_back(4'hF);
    do_start(4'b0000);
    do_nib(4'b0010);
    do_nib(4'h0);
    do_nib(4'h0);
    do_start(4'b0000);
    chk("abort_addr_reqValid", 32'(reqValid), 32'd0);
    do_nib(4'b0010);
    send_addr(32'h2F, 4);
    do_nib(4'h1);
    do_nib(4'h1);
    do_nib(4'hF);
    do_nib(4'hF);
    step();
    step();
    step();
    chk("abort_addr_restart_addr", addr, 32'h2F);
    chk("abort_addr_restart_data", 32'(outData), 32'h11);
    chk("abort_addr_dw_count", 32'(n_dw), 32'd1);
    chk("abort_addr_q_empty", 32'(exp_q.size()), 32'd0);

    // LFRAME# drops during a long wait: release LAD and the request.
    clr_counts();
    reqReady = 1'b0;
    exp_q.push_back(4'b0110);
    do_start(4'b0000);
    do_nib(4'b0000);
    send_addr(32'h2E, 4);
    do_nib(4'hF);
    do_nib(4'hF);
    do_start(4'b0000);
    chk("abort_sync_enable", 32'(enable), 32'd0);
    chk("abort_sync_reqValid", 32'(reqValid), 32'd0);
    do_nib(4'b1111);
    step();
    step();
    chk("abort_sync_dr_count", 32'(n_dr), 32'd0);
    chk("abort_sync_q_empty", 32'(exp_q.size()), 32'd0);

    // Backend never ready: four long waits then an error SYNC.
    clr_counts();
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b1010);
    exp_q.push_back(4'b1111);
    do_start(4'b0000);
    do_nib(4'b0000);
    send_addr(32'h2E, 4);
    do_nib(4'hF);
    do_nib(4'hF);
    step();
    step();
    step();
    step();
    chk("to_syncError", 32'(syncError), 32'd1);
    chk("to_reqValid", 32'(reqValid), 32'd0);
    step();
    chk("to_syncError_clear", 32'(syncError), 32'd0);
    step();
    step();
    chk("to_se_count", 32'(n_se), 32'd1);
    chk("to_dr_count", 32'(n_dr), 32'd0);
    chk("to_q_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset during SYNC clears outputs without a clock edge.
    clr_counts();
    exp_q.push_back(4'b0110);
    do_start(4'b0000);
    do_nib(4'b0000);
    send_addr(32'h2E, 4);
    do_nib(4'hF);
    do_nib(4'hF);
    #2;
    rstN = 1'b0;
    #1;
    chk("arst_enable", 32'(enable), 32'd0);
    chk("arst_outAd", 32'(outAd), 32'hF);
    chk("arst_reqValid", 32'(reqValid), 32'd0);
    chk("arst_addr", addr, 32'd0);
    #1;
    rstN = 1'b1;
    step();
    step();
    chk("arst_q_empty", 32'(exp_q.size()), 32'd0);

    // Write with one busy cycle after reset: exactly one long wait.
    clr_counts();
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b1111);
    do_start(4'b0000);
    do_nib(4'b0010);
    send_addr(32'h2E, 4);
    do_nib(4'h5);
    do_nib(4'hA);
    do_nib(4'hF);
    do_nib(4'hF);
    reqReady = 1'b1;
    step();
    reqReady = 1'b0;
    step();
    chk("wait1_didWrite", 32'(didWrite), 32'd1);
    step();
    step();
    chk("wait1_outData", 32'(outData), 32'hA5);
    chk("wait1_dw_count", 32'(n_dw), 32'd1);
    chk("wait1_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
